rr_req_gnt_arbiter: RTL and testbench
=====================================

// Module: rr_req_gnt_arbiter
// PURPOSE
//  Round-robin arbiter sharing one resource among NUM_REQ requesters over a req/gnt handshake.
//  Idle resource: a rising req is granted on the next clk edge, so rose(req) |=> rose(gnt) holds.
//  Grant is held while the owner keeps req high, up to MAX_HOLD cycles; then it is revoked.
//  Sits between requesting engines and the shared resource; gnt_id drives the resource's input mux.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..16
//  MAX_HOLD  16  max consecutive grant cycles per tenure; 0 = unlimited; counter width $clog2(MAX_HOLD+1)
// PORTS
//  clk      in   1               single clock, all flops on posedge
//  rst      in   1               asynchronous, active-high reset
//  req      in   NUM_REQ         level requests, one bit per requester
//  gnt      out  NUM_REQ         one-hot0 grant, registered
//  gnt_id   out  $clog2(NUM_REQ) index of owner; valid only while busy
//  busy     out  1               resource owned (|gnt)
//  expire   out  1               1-cycle pulse when a grant is revoked by MAX_HOLD
// BEHAVIOUR
//  Reset (async assert, sync release): gnt=0, gnt_id=0, busy=0, expire=0, state=IDLE, ptr=0, hold_cnt=0.
//  States: IDLE, OWN, GAP.
//  IDLE: if |req, pick winner = first set bit scanning ptr, ptr+1, ... wrapping mod NUM_REQ;
//   next edge: gnt[winner]=1, gnt_id=winner, hold_cnt=1, ->OWN. No req: stay IDLE.
//  OWN: req[gnt_id]=0 -> next edge gnt=0, ptr=gnt_id+1 (wrap), ->GAP.
//   req[gnt_id]=1 and MAX_HOLD!=0 and hold_cnt==MAX_HOLD -> next edge gnt=0, expire=1,
//   ptr=gnt_id+1 (wrap), ->GAP. Otherwise hold_cnt++ (saturates; never wraps).
//  GAP: one dead cycle, gnt=0, -> IDLE; arbitration resumes next cycle (no back-to-back owner swap).
//  Latency: req rise in IDLE -> gnt on next edge; req drop -> gnt drop on next edge; total
//   handover between owners = 3 edges (drop, GAP, grant).
//  Simultaneous requests: single winner per rule above; losers wait, no starvation (ptr rotation).
//  Expired owner holding req stays eligible but ranks last after ptr advance.
//  Requests rising in OWN/GAP are not lost: req is level; serviced at next IDLE decision.
//  rst mid-tenure: gnt drops asynchronously, ptr returns to 0.
//  gnt never asserted for a requester whose req was low at the deciding edge.
// CONFIGURATION
//  RR_REQ_GNT_ARB_SVA_EN defined: module contains concurrent assertions clocked on posedge clk,
//   disabled iff (rst): $onehot0(gnt); gnt[i] |-> $past(req[i]);
//   (state==IDLE && $rose(req[i]) && $past(!req[i],1) && $onehot(req)) |=> $rose(gnt[i]);
//   (MAX_HOLD!=0) no gnt bit high longer than MAX_HOLD consecutive cycles; expire |-> !busy.
//  Undefined: no assertions compiled; RTL and timing otherwise identical.
// STRUCTURE
//  Package rr_arb_pkg: typedef enum logic [1:0] {IDLE, OWN, GAP} arb_state_t;
//   function rr_pick(req, ptr) returning winner index and found flag.
//  Sub-module rr_arb_pick: combinational rotate-priority picker (req, ptr -> idx, any), instantiated once.
//  Top: state register, ptr, hold_cnt, gnt/gnt_id/expire output registers, optional SVA block.
// TESTING
//  1 Reset, req=0 10 cycles -> gnt=0, busy=0, expire=0 throughout.
//  2 req=4'b0001 rises in IDLE -> next edge gnt=4'b0001, gnt_id=0; drop req -> gnt=0 next edge, GAP, ptr=1.
//  3 req=4'b1111 held, MAX_HOLD=0, each owner drops after 2 cycles -> grant order 0,1,2,3,0.
//  4 MAX_HOLD=16, req=4'b0100 held 40 cycles -> gnt[2] exactly 16 cycles, expire pulse, GAP, re-granted.
//  5 Owner 1 holding, req[3] rises -> no gnt[3] until 1 drops; then GAP then gnt=4'b1000.
//  6 rst asserted mid-tenure with gnt=4'b0010 -> gnt=0 immediately; after release, req=4'b0011 -> gnt=4'b0001.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
//   Shared types and helpers for the round-robin req/gnt arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, OWN, GAP)
//   - pick_t      : result of a rotate-priority search (found flag + index)
//   - rr_pick()   : first set request bit scanning ptr, ptr+1, ... mod n
// -----------------------------------------------------------------------------
package rr_arb_pkg;

  // Widest configuration supported by the picker helper.
  localparam int MAX_REQ = 16;
  localparam int PTR_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } pick_t;

  // Scan n requesters starting at ptr, wrapping at n. Request bits at or above
  // n are ignored. n is a module parameter at every call site, so the loop
  // unrolls into a fixed priority network.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [PTR_W-1:0]   ptr,
                                    input int                 n);
    pick_t res;
    int    c;
    res.found = 1'b0;
    res.idx   = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n && !res.found) begin
        c = int'(ptr) + k;
        if (c >= n) c = c - n;
        if (req[PTR_W'(c)]) begin
          res.found = 1'b1;
          res.idx   = PTR_W'(c);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// -----------------------------------------------------------------------------
// rr_arb_pick
//   Combinational rotate-priority picker. Returns the first requester with its
//   req bit set, scanning from ptr upwards and wrapping at NUM_REQ.
// Ports:
//   req  in  NUM_REQ          request vector
//   ptr  in  $clog2(NUM_REQ)  highest-priority index this decision
//   idx  out $clog2(NUM_REQ)  winning index (meaningful only when any=1)
//   any  out 1                at least one request present
// -----------------------------------------------------------------------------
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [MAX_REQ-1:0] req_ext;
  pick_t              pick_res;

  // Zero-extend the request vector to the helper's fixed width.
  generate
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_ext
      if (gi < NUM_REQ) begin : g_live
        assign req_ext[gi] = req[gi];
      end else begin : g_pad
        assign req_ext[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    pick_res = rr_pick(req_ext, PTR_W'(ptr), NUM_REQ);
    idx      = IDW'(pick_res.idx);
    any      = pick_res.found;
  end

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// -----------------------------------------------------------------------------
// rr_req_gnt_arbiter
//   Round-robin arbiter sharing one resource among NUM_REQ requesters over a
//   level req / registered gnt handshake. An owner keeps the grant while its
//   req stays high, for at most MAX_HOLD cycles (0 = unlimited). Every tenure
//   is followed by one dead GAP cycle before the next decision.
// Parameters:
//   NUM_REQ   number of requesters (2..16)
//   MAX_HOLD  max consecutive grant cycles per tenure, 0 = unlimited
// Ports:
//   clk     in   1                single clock, posedge
//   rst     in   1                asynchronous active-high reset
//   req     in   NUM_REQ          level requests
//   gnt     out  NUM_REQ          one-hot0 registered grant
//   gnt_id  out  $clog2(NUM_REQ)  owner index, valid while busy
//   busy    out  1                resource owned (|gnt)
//   expire  out  1                1-cycle pulse when MAX_HOLD revokes a grant
// Configuration:
//   RR_REQ_GNT_ARB_SVA_EN  when defined, compiles concurrent assertions on the
//                          grant protocol; behaviour is otherwise identical.
// -----------------------------------------------------------------------------
module rr_req_gnt_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       expire
);

  localparam int IDW = $clog2(NUM_REQ);
  // With unlimited hold the counter is still kept (1 bit, saturating) so the
  // datapath does not change shape between configurations.
  localparam int HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_SAT = '1;
  localparam logic [HCW-1:0] HOLD_LIM = (MAX_HOLD == 0) ? HOLD_SAT : HCW'(MAX_HOLD);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           expire_q, expire_d;

  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic [IDW-1:0] ptr_after_owner;
  logic           owner_req;
  logic           hold_limit_hit;

  rr_arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // After any tenure the owner drops to lowest priority.
  assign ptr_after_owner = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + IDW'(1);
  assign owner_req       = req[gnt_id_q];
  assign hold_limit_hit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    expire_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          gnt_id_d        = pick_idx;
          hold_cnt_d      = HCW'(1);
          state_d         = OWN;
        end
      end

      OWN: begin
        if (!owner_req) begin
          gnt_d   = '0;
          ptr_d   = ptr_after_owner;
          state_d = GAP;
        end else if (hold_limit_hit) begin
          gnt_d    = '0;
          expire_d = 1'b1;
          ptr_d    = ptr_after_owner;
          state_d  = GAP;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end

      GAP: begin
        // Dead cycle so two owners never see back-to-back grants.
        gnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      expire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      expire_q   <= expire_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = |gnt_q;
  assign expire = expire_q;

`ifdef RR_REQ_GNT_ARB_SVA_EN
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

  a_expire_not_busy: assert property (@(posedge clk) disable iff (rst) expire |-> !busy);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sva_req
      a_gnt_had_req: assert property (@(posedge clk) disable iff (rst)
        gnt[gi] |-> $past(req[gi]));

      a_idle_rise_granted: assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE && $rose(req[gi]) && $past(!req[gi], 1) && $onehot(req))
          |=> $rose(gnt[gi]));
    end

    if (MAX_HOLD != 0) begin : g_sva_hold
      // Tenures are separated by GAP, so a busy run equals one tenure.
      logic [HCW:0] sva_run_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sva_run_q <= '0;
        end else if (busy) begin
          if (sva_run_q != '1) sva_run_q <= sva_run_q + (HCW+1)'(1);
        end else begin
          sva_run_q <= '0;
        end
      end

      a_hold_limit: assert property (@(posedge clk) disable iff (rst)
        sva_run_q <= (HCW+1)'(MAX_HOLD));
    end
  endgenerate
`endif

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
module tb_rr_req_gnt_arbiter;

  localparam int N  = 4;
  localparam int MH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         expire;

  always #5 clk = ~clk;

  rr_req_gnt_arbiter #(
    .NUM_REQ  (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .expire (expire)
  );

  typedef struct {
    logic [N-1:0] gnt;
    logic [1:0]   id;
    logic         busy;
    logic         exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // ---------------------------------------------------------------------------
  // Reference model: owner/pointer bookkeeping in plain integers. Every posedge
  // it applies the arbitration rules to the sampled req and pushes the output
  // the DUT must show after that edge.
  // ---------------------------------------------------------------------------
  int m_phase;   // 0 free, 1 owned, 2 dead cycle
  int m_ptr;
  int m_own;
  int m_held;
  bit m_exp;

  initial begin
    exp_t e;
    m_phase = 0; m_ptr = 0; m_own = 0; m_held = 0; m_exp = 0;
    forever begin
      @(posedge clk);
      m_exp = 0;
      if (rst) begin
        m_phase = 0; m_ptr = 0; m_own = 0; m_held = 0;
      end else if (m_phase == 0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (req[c]) begin
            m_own = c; m_held = 1; m_phase = 1;
            break;
          end
        end
      end else if (m_phase == 1) begin
        if (!req[m_own] || m_held == MH) begin
          m_exp   = req[m_own];
          m_ptr   = (m_own + 1) % N;
          m_phase = 2;
        end else begin
          m_held = m_held + 1;
        end
      end else begin
        m_phase = 0;
      end
      e.gnt  = (m_phase == 1) ? N'(1 << m_own) : '0;
      e.id   = 2'(m_own);
      e.busy = (m_phase == 1);
      e.exp  = m_exp;
      sb_q.push_back(e);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops one expectation per cycle and compares away from the edge.
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (gnt !== e.gnt || busy !== e.busy || expire !== e.exp ||
            (e.busy && gnt_id !== e.id)) begin
          n_bad++;
          $display("FAIL sb t=%0t: got gnt=%b id=%0d busy=%b expire=%b, want gnt=%b id=%0d busy=%b expire=%b",
                   $time, gnt, gnt_id, busy, expire, e.gnt, e.id, e.busy, e.exp);
        end
        if (busy && !prev_busy) $display("grant id=%0d t=%0t", gnt_id, $time);
        if (expire) $display("expire t=%0t", $time);
        prev_busy = busy;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0h want %0h", nm, $time, act, want);
    end
  endtask

  task automatic wait_busy(input string nm, input int budget);
    int t;
    t = 0;
    while (busy !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: busy=%b after %0d cycles", nm, busy, t);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int id;
    int run, first_run, exps, regrant;

    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", {28'd0, gnt, busy, expire} , 32'd0);
    end

    // Single requester 0: grant next edge, drop next edge, ptr moves to 1
    req = 4'b0001;
    @(negedge clk);
    chk("t2_gnt", 32'(gnt), 32'h1);
    chk("t2_id", 32'(gnt_id), 32'd0);
    repeat (2) @(negedge clk);
    req = '0;
    @(negedge clk);
    chk("t2_drop", 32'(gnt), 32'd0);
    @(negedge clk);
    req = 4'b0011;
    @(negedge clk);
    chk("t2_ptr1", 32'(gnt), 32'h2);
    req = '0;
    repeat (3) @(negedge clk);

    // All requesting, each owner drops after 2 cycles: order 0,1,2,3,0
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_busy("t3_wait", 20);
      id = int'(gnt_id);
      chk("t3_order", 32'(id), 32'(k % 4));
      @(negedge clk);
      req[id] = 1'b0;
      @(negedge clk);
      if (k < 4) req[id] = 1'b1;
      else req = '0;
    end
    repeat (3) @(negedge clk);

    // Continuous request from 2: 16-cycle tenure, expire, gap, regrant
    req = 4'b0100;
    run = 0; first_run = -1; exps = 0; regrant = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt[2]) begin
        run++;
        if (first_run >= 0) regrant = 1;
      end else begin
        if (run > 0 && first_run < 0) first_run = run;
        run = 0;
      end
      if (expire) exps++;
    end
    chk("t4_run", 32'(first_run), 32'd16);
    chk("t4_expires", 32'(exps), 32'd2);
    chk("t4_regrant", 32'(regrant), 32'd1);
    req = '0;
    repeat (3) @(negedge clk);

    // Owner 1 holds while 3 waits; 3 granted two cycles after 1 releases
    req = 4'b0010;
    wait_busy("t5_wait", 10);
    chk("t5_owner", 32'(gnt_id), 32'd1);
    repeat (2) @(negedge clk);
    req = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold", 32'(gnt), 32'h2);
    end
    req = 4'b1000;
    @(negedge clk);
    chk("t5_drop", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("t5_gap", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("t5_next", 32'(gnt), 32'h8);

    // Reset mid-tenure
    req = '0;
    repeat (3) @(negedge clk);
    req = 4'b0010;
    wait_busy("t6_wait", 10);
    chk("t6_own", 32'(gnt), 32'h2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_gnt", 32'(gnt), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0011;
    @(negedge clk);
    chk("t6_after", 32'(gnt), 32'h1);

    // Random traffic, checked cycle by cycle by the scoreboard
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
    end

    req = '0;
    repeat (4) @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
